// File: rtl/datapath_sequencer.sv
// datapath_sequencer: single-step Moore controller that runs one 4-bit instruction per start rise
module datapath_sequencer #(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] op,
    output logic       l1,
    output logic       l2,
    output logic       l3,
    output logic       l4,
    output logic [2:0] s1,
    output logic [2:0] s2,
    output logic       f,
    output logic       r,
    output logic       w,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM1, MEM2, DONE} state_t;
    state_t     state, state_nx;
    logic [3:0] ir;
    logic [2:0] cnt;
    logic       start_q;
    logic       start_rise;
    logic [3:0] ld;
    logic [1:0] idx;
    assign idx        = ir[1:0];
    assign start_rise = start & ~start_q;
    assign {l4, l3, l2, l1} = ld;
    // State, latched instruction, memory wait counter and start edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ir      <= '0;
            cnt     <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= start;
            if (state == IDLE && start_rise) ir <= op;
            if (state == DECODE) cnt <= 3'(MEM_WAIT);
            else if (state == MEM1 && cnt != 3'd0) cnt <= cnt - 3'd1;
        end
    end
    // Next state: rises outside IDLE are dropped, memory ops stretch MEM1 by the wait count
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = start_rise ? DECODE : IDLE;
            DECODE:  state_nx = ir[3] ? MEM1 : EXEC;
            EXEC:    state_nx = DONE;
            MEM1:    state_nx = (cnt == 3'd0) ? MEM2 : MEM1;
            MEM2:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    // Output decode from registered state and instruction; ir[2] splits ADD/LOAD and FETCH/STORE
    always_comb begin
        ld   = '0;
        s1   = '0;
        s2   = '0;
        f    = 1'b0;
        r    = 1'b0;
        w    = 1'b0;
        busy = state != IDLE;
        done = state == DONE;
        case (state)
            EXEC: begin
                ld = 4'b0001 << idx;
                s1 = ir[2] ? {1'b0, idx} : 3'd4;
                s2 = ir[2] ? 3'd3 : 3'd5;
            end
            MEM1: begin
                r  = ir[2];
                w  = ~ir[2];
                s1 = ir[2] ? 3'd0 : {1'b0, idx};
            end
            MEM2: begin
                r  = ir[2];
                w  = ~ir[2];
                s1 = ir[2] ? 3'd6 : {1'b0, idx};
                ld = ir[2] ? 4'b0001 << idx : 4'b0000;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle control unit that sequences the four-register datapath. It issues the register load enables l1..l4, the operand selects s1/s2, the ALU function f, and the memory strobes r/w. It executes one 4-bit instruction for each rising edge of start, so a debounced push-button or the clock-control block can single-step the machine. It sits beside the datapath and replaces the free-running controller when instructions are entered by hand.

Parameters:
MEM_WAIT, 1, extra wait cycles spent in MEM1 before MEM2 (legal 0..7)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  level input; a rising edge requests execution of op
op  input  4  instruction: op[3:2] opcode, op[1:0] register index (0..3 = R1..R4)
l1  output  1  load enable R1
l2  output  1  load enable R2
l3  output  1  load enable R3
l4  output  1  load enable R4
s1  output  3  operand A select: 0-3 = R1..R4, 4 = switch input x, 6 = memory read data
s2  output  3  operand B select: 0-3 = R1..R4, 5 = constant zero
f  output  1  ALU function: 0 add, 1 subtract
r  output  1  memory read strobe
w  output  1  memory write strobe
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at instruction completion

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; ir=0; wait counter=0; start_q=0.
  - All outputs 0, including busy and done.
  - Outputs clear immediately, even mid-instruction; no partial load or strobe continues after reset.
- Start detection:
  - start_q registers start every cycle.
  - start_rise = start & ~start_q.
  - A start_rise is accepted only in IDLE. Rises in any other state are ignored and are not queued.
  - A held-high start executes exactly one instruction.
- Opcodes:
  - 00 LOAD: R[idx] <= x
  - 01 ADD: R[idx] <= R[idx] + R4
  - 10 STORE: mem <= R[idx]
  - 11 FETCH: R[idx] <= mem
- State machine (Moore; outputs decode from registered state and ir; default output is all 0):
  - IDLE: on start_rise, ir <= op, go to DECODE.
  - DECODE: all outputs 0 except busy; 1 cycle. Opcode 00/01 -> EXEC; 10/11 -> MEM1, wait counter <= MEM_WAIT.
  - EXEC, LOAD: s1=4, s2=5, f=0, l[idx]=1.
  - EXEC, ADD: s1=idx, s2=3, f=0, l[idx]=1.
  - EXEC: 1 cycle, then -> DONE.
  - MEM1, STORE: s1=idx, w=1.
  - MEM1, FETCH: r=1.
  - MEM1 exit: stay while wait counter != 0, decrementing it each cycle; when it is 0 -> MEM2.
  - MEM2, STORE: s1=idx, w=1.
  - MEM2, FETCH: r=1, s1=6, l[idx]=1.
  - MEM2: 1 cycle, then -> DONE.
  - DONE: done=1, busy=1; 1 cycle, then -> IDLE.
- Invariants:
  - At most one of l1..l4 is high in any cycle.
  - r and w are never high together.
  - l[idx] is high for exactly one cycle per LOAD, ADD or FETCH, and never for STORE.
- Latency (cycle 0 = edge sampling start_rise):
  - LOAD/ADD: load in cycle 2, done in cycle 3, busy high for cycles 1-3.
  - STORE/FETCH: MEM1 spans cycles 2..2+MEM_WAIT; MEM2 at 3+MEM_WAIT; done at 4+MEM_WAIT.
  - Strobe width = MEM_WAIT+2 cycles.
- Boundary cases:
  - op may change after acceptance without effect; ir holds it.
  - A start_rise in the DONE cycle is ignored; a new rise is needed after returning to IDLE.
  - With MEM_WAIT=0, MEM1 lasts exactly 1 cycle.
  - idx=3 with ADD gives R4 <= R4+R4 (s1=3, s2=3).

Test Plan:
- Reset: hold rst_n=0, toggle start, op=4'b0001 -> all outputs 0 and busy=0. Release rst_n, then raise start -> l2=1, s1=4, s2=5 in cycle 2; done=1 in cycle 3; l1/l3/l4 stay 0.
- ADD: op=4'b0110 (ADD R3), start rise -> cycle 2 shows s1=2, s2=3, f=0, l3=1 for one cycle; busy high for 3 cycles.
- STORE, MEM_WAIT=1: op=4'b1000 -> w=1 with s1=0 in cycles 2-4, r=0 throughout, no l*; done in cycle 5.
- FETCH, MEM_WAIT=0: op=4'b1111 -> r=1 in cycles 2-3; cycle 3 also s1=6, l4=1; done in cycle 4.
- Held start: start held high across 3 instruction lengths -> exactly one done pulse. A second rise during busy or in the DONE cycle -> ignored; a rise after IDLE -> second execution.
- Reset mid-op: assert rst_n=0 during MEM1 of a FETCH -> r drops to 0 asynchronously, no l4 pulse occurs, state IDLE, busy=0.
